// File: rtl/vrf_pkg.sv
// -----------------------------------------------------------------------------
// vrf_pkg
// Shared types and default sizes for the SIMT vector register file.
//   lane_t      : one lane element at the default width
//   vec_t       : one register across all default lanes
//   rsel_t      : register select at the default register count
//   clr_state_t : bulk-clear engine state
// -----------------------------------------------------------------------------
package vrf_pkg;

   localparam int THREADS_DEF = 4;
   localparam int NREGS_DEF   = 32;
   localparam int WIDTH_DEF   = 32;

   typedef logic [WIDTH_DEF-1:0]          lane_t;
   typedef lane_t [THREADS_DEF-1:0]       vec_t;
   typedef logic [$clog2(NREGS_DEF)-1:0]  rsel_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

endpackage

// File: rtl/vrf_scoreboard.sv
// -----------------------------------------------------------------------------
// vrf_scoreboard
// One busy bit per register tracking in-flight writes.
//   clk, rst            : clock, asynchronous active-high reset
//   rsv_en, rsv_sel     : reserve a destination register (sets busy)
//   ret_en, ret_sel     : last write of an instruction retires (clears busy)
//   eng_clr_en/_sel     : bulk-clear engine wipes one busy bit
//   rsel1, rsel2        : read selects used for hazard detection
//   hazard              : either read select names a busy register
//   busy_vec            : all busy bits, for trace
// Register 0 is never reserved; its bit is forced to 0.
// -----------------------------------------------------------------------------
module vrf_scoreboard
   import vrf_pkg::*;
#(
   parameter  int NREGS = NREGS_DEF,
   localparam int RBITS = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rsv_en,
   input  logic [RBITS-1:0] rsv_sel,
   input  logic             ret_en,
   input  logic [RBITS-1:0] ret_sel,
   input  logic             eng_clr_en,
   input  logic [RBITS-1:0] eng_clr_sel,
   input  logic [RBITS-1:0] rsel1,
   input  logic [RBITS-1:0] rsel2,
   output logic             hazard,
   output logic [NREGS-1:0] busy_vec
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;

   // Clears are applied first so that a reservation issued behind a
   // retiring write to the same register leaves the bit set.
   always_comb begin
      busy_d = busy_q;
      if (ret_en && (ret_sel != '0)) begin
         busy_d[ret_sel] = 1'b0;
      end
      if (eng_clr_en) begin
         busy_d[eng_clr_sel] = 1'b0;
      end
      if (rsv_en && (rsv_sel != '0)) begin
         busy_d[rsv_sel] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign hazard   = busy_q[rsel1] | busy_q[rsel2];
   assign busy_vec = busy_q;

endmodule

// File: rtl/vector_register_file_sb.sv
// -----------------------------------------------------------------------------
// vector_register_file_sb
// Per-thread vector register file: one lane-masked write port, two registered
// read ports with write-to-read bypass, a busy scoreboard and a bulk-clear
// engine.
//   clk, RST         : clock, asynchronous active-high reset
//   wen/wsel/wdata   : lane-masked write, lane i at wdata[i*WIDTH +: WIDTH]
//   wlast            : write retires the instruction (clears busy[wsel])
//   rsel1/rsel2      : read selects, sampled at posedge
//   rdata1/rdata2    : registered read data, valid the cycle after the select
//   rsv_en/rsv_sel   : reserve a destination register
//   hazard           : combinational busy check on rsel1/rsel2
//   busy_vec         : scoreboard bits
//   clr_req          : start bulk clear of registers 1..NREGS-1
//   clr_busy         : bulk clear in progress; external updates are dropped
// -----------------------------------------------------------------------------
module vector_register_file_sb
   import vrf_pkg::*;
#(
   parameter  int THREADS = THREADS_DEF,
   parameter  int NREGS   = NREGS_DEF,
   parameter  int WIDTH   = WIDTH_DEF,
   localparam int RBITS   = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic [THREADS-1:0]       wen,
   input  logic [RBITS-1:0]         wsel,
   input  logic [THREADS*WIDTH-1:0] wdata,
   input  logic                     wlast,
   input  logic [RBITS-1:0]         rsel1,
   input  logic [RBITS-1:0]         rsel2,
   output logic [THREADS*WIDTH-1:0] rdata1,
   output logic [THREADS*WIDTH-1:0] rdata2,
   input  logic                     rsv_en,
   input  logic [RBITS-1:0]         rsv_sel,
   output logic                     hazard,
   output logic [NREGS-1:0]         busy_vec,
   input  logic                     clr_req,
   output logic                     clr_busy
);

   logic [WIDTH-1:0]         mem_q [NREGS][THREADS];
   logic [WIDTH-1:0]         mem_d [NREGS][THREADS];
   logic [THREADS*WIDTH-1:0] rdata1_q, rdata1_d;
   logic [THREADS*WIDTH-1:0] rdata2_q, rdata2_d;
   clr_state_t               state_q, state_d;
   logic [RBITS-1:0]         cnt_q, cnt_d;
   logic                     clr_busy_q, clr_busy_d;

   logic idle;
   logic wr_cmt;

   // External updates only take effect while the clear engine is idle.
   assign idle   = (state_q == IDLE);
   assign wr_cmt = idle && (wsel != '0);

   // Storage next-state: external write, then the clear engine slot.
   always_comb begin
      mem_d = mem_q;
      if (wr_cmt) begin
         for (int i = 0; i < THREADS; i++) begin
            if (wen[i]) begin
               mem_d[wsel][i] = wdata[i*WIDTH +: WIDTH];
            end
         end
      end
      if (state_q == CLEAR) begin
         for (int i = 0; i < THREADS; i++) begin
            mem_d[cnt_q][i] = '0;
         end
      end
   end

   // Read pipeline with per-lane bypass from a committing write. The clear
   // engine is deliberately not bypassed.
   always_comb begin
      rdata1_d = '0;
      rdata2_d = '0;
      for (int i = 0; i < THREADS; i++) begin
         if (wr_cmt && wen[i] && (wsel == rsel1)) begin
            rdata1_d[i*WIDTH +: WIDTH] = wdata[i*WIDTH +: WIDTH];
         end else begin
            rdata1_d[i*WIDTH +: WIDTH] = mem_q[rsel1][i];
         end
         if (wr_cmt && wen[i] && (wsel == rsel2)) begin
            rdata2_d[i*WIDTH +: WIDTH] = wdata[i*WIDTH +: WIDTH];
         end else begin
            rdata2_d[i*WIDTH +: WIDTH] = mem_q[rsel2][i];
         end
      end
   end

   // Clear engine: walks registers 1..NREGS-1, one per cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (clr_req) begin
               state_d = CLEAR;
               cnt_d   = RBITS'(1);
            end
         end
         CLEAR: begin
            if (cnt_q == RBITS'(NREGS - 1)) begin
               state_d = IDLE;
               cnt_d   = RBITS'(1);
            end else begin
               cnt_d = cnt_q + RBITS'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = RBITS'(1);
         end
      endcase
      clr_busy_d = (state_d == CLEAR);
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int r = 0; r < NREGS; r++) begin
            for (int i = 0; i < THREADS; i++) begin
               mem_q[r][i] <= '0;
            end
         end
         rdata1_q   <= '0;
         rdata2_q   <= '0;
         state_q    <= IDLE;
         cnt_q      <= RBITS'(1);
         clr_busy_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         rdata1_q   <= rdata1_d;
         rdata2_q   <= rdata2_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         clr_busy_q <= clr_busy_d;
      end
   end

   vrf_scoreboard #(
      .NREGS (NREGS)
   ) u_sb (
      .clk         (clk),
      .rst         (RST),
      .rsv_en      (rsv_en && idle),
      .rsv_sel     (rsv_sel),
      .ret_en      (wlast && idle),
      .ret_sel     (wsel),
      .eng_clr_en  (state_q == CLEAR),
      .eng_clr_sel (cnt_q),
      .rsel1       (rsel1),
      .rsel2       (rsel2),
      .hazard      (hazard),
      .busy_vec    (busy_vec)
   );

   assign rdata1   = rdata1_q;
   assign rdata2   = rdata2_q;
   assign clr_busy = clr_busy_q;

endmodule

// File: tb/tb_vector_register_file_sb.sv
module tb_vector_register_file_sb;

   localparam int THREADS = 4;
   localparam int NREGS   = 32;
   localparam int WIDTH   = 32;
   localparam int RBITS   = 5;
   localparam int VW      = THREADS * WIDTH;

   logic             clk;
   logic             rst;
   logic [THREADS-1:0] wen;
   logic [RBITS-1:0] wsel;
   logic [VW-1:0]    wdata;
   logic             wlast;
   logic [RBITS-1:0] rsel1;
   logic [RBITS-1:0] rsel2;
   logic [VW-1:0]    rdata1;
   logic [VW-1:0]    rdata2;
   logic             rsv_en;
   logic [RBITS-1:0] rsv_sel;
   logic             hazard;
   logic [NREGS-1:0] busy_vec;
   logic             clr_req;
   logic             clr_busy;

   int total = 0;
   int bad   = 0;

   vector_register_file_sb #(
      .THREADS (THREADS),
      .NREGS   (NREGS),
      .WIDTH   (WIDTH)
   ) dut (
      .clk      (clk),
      .RST      (rst),
      .wen      (wen),
      .wsel     (wsel),
      .wdata    (wdata),
      .wlast    (wlast),
      .rsel1    (rsel1),
      .rsel2    (rsel2),
      .rdata1   (rdata1),
      .rdata2   (rdata2),
      .rsv_en   (rsv_en),
      .rsv_sel  (rsv_sel),
      .hazard   (hazard),
      .busy_vec (busy_vec),
      .clr_req  (clr_req),
      .clr_busy (clr_busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [WIDTH-1:0] m_mem [NREGS][THREADS];
   logic [NREGS-1:0] m_busy;
   logic [VW-1:0]    m_rd1, m_rd2;
   bit               m_clr;
   int               m_idx;

   function automatic logic [VW-1:0] m_vec(input int r);
      logic [VW-1:0] v;
      for (int i = 0; i < THREADS; i++) v[i*WIDTH +: WIDTH] = m_mem[r][i];
      return v;
   endfunction

   function automatic logic [VW-1:0] rep(input logic [WIDTH-1:0] x);
      return {THREADS{x}};
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NREGS; r++)
         for (int i = 0; i < THREADS; i++) m_mem[r][i] = '0;
      m_busy = '0;
      m_rd1  = '0;
      m_rd2  = '0;
      m_clr  = 0;
      m_idx  = 1;
   endtask

   // One clock edge of architectural behaviour. Reads see the register
   // contents including this edge's write (bypass), but not this edge's clear.
   task automatic model_step();
      if (!m_clr && wsel != 0) begin
         for (int i = 0; i < THREADS; i++)
            if (wen[i]) m_mem[wsel][i] = wdata[i*WIDTH +: WIDTH];
      end
      m_rd1 = m_vec(int'(rsel1));
      m_rd2 = m_vec(int'(rsel2));
      if (m_clr) begin
         for (int i = 0; i < THREADS; i++) m_mem[m_idx][i] = '0;
         m_busy[m_idx] = 1'b0;
         m_idx++;
         if (m_idx == NREGS) m_clr = 0;
      end else begin
         if (wlast && wsel != 0) m_busy[wsel] = 1'b0;
         if (rsv_en && rsv_sel != 0) m_busy[rsv_sel] = 1'b1;
         if (clr_req) begin
            m_clr = 1;
            m_idx = 1;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      wen = '0; wsel = '0; wdata = '0; wlast = 1'b0;
      rsel1 = '0; rsel2 = '0; rsv_en = 1'b0; rsv_sel = '0; clr_req = 1'b0;
   endtask

   // Inputs are driven at posedge+1; hazard checked at negedge, registered
   // outputs checked at posedge+1.
   task automatic cycle();
      @(negedge clk);
      check_eq("hazard", hazard, m_busy[rsel1] | m_busy[rsel2]);
      @(posedge clk);
      model_step();
      #1;
      check_eq("rdata1", rdata1, m_rd1);
      check_eq("rdata2", rdata2, m_rd2);
      check_eq("busy_vec", busy_vec, m_busy);
      check_eq("clr_busy", clr_busy, m_clr);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      #1;
      check_eq("rst_rdata1", rdata1, '0);
      check_eq("rst_rdata2", rdata2, '0);
      check_eq("rst_busy", busy_vec, '0);
      check_eq("rst_clr_busy", clr_busy, 1'b0);
      check_eq("rst_hazard", hazard, 1'b0);
      model_reset();
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic write_reg(input int r, input logic [THREADS-1:0] m, input logic [VW-1:0] d, input bit last);
      wsel = RBITS'(r); wen = m; wdata = d; wlast = last;
   endtask

   task automatic run_clear(input int drop_at, output int n);
      n = 0;
      while (clr_busy === 1'b1 && n < 40) begin
         idle_inputs();
         rsel1 = RBITS'($urandom_range(0, NREGS - 1));
         rsel2 = 5'd20;
         if (n == drop_at) begin
            write_reg(2, 4'b1111, rep(32'h1234_5678), 1'b1);
            rsv_en = 1'b1; rsv_sel = 5'd6;
         end
         cycle();
         n++;
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      bad++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      idle_inputs();
      rst = 1'b1;
      model_reset();
      #12;
      check_eq("init_rdata1", rdata1, '0);
      check_eq("init_busy", busy_vec, '0);
      check_eq("init_clr_busy", clr_busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: async reset mid-operation
      write_reg(5, 4'b1111, rep(32'hDEAD_BEEF), 1'b0);
      rsv_en = 1'b1; rsv_sel = 5'd5;
      cycle();
      idle_inputs(); rsel1 = 5'd5; rsel2 = 5'd5;
      cycle();
      check_eq("t1_rd_before_rst", rdata1, rep(32'hDEAD_BEEF));
      reset_pulse();
      idle_inputs(); rsel1 = 5'd5;
      cycle();
      check_eq("t1_reg5_after_rst", rdata1, '0);

      // 2: masked lane write
      write_reg(3, 4'b1111, rep(32'hFF), 1'b0);
      cycle();
      write_reg(3, 4'b0101, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0);
      cycle();
      idle_inputs(); rsel1 = 5'd3;
      cycle();
      check_eq("t2_masked", rdata1, {32'hFF, 32'h3, 32'hFF, 32'h1});

      // 3: bypass and register 0
      write_reg(7, 4'b1111, rep(32'hA5), 1'b0);
      rsel1 = 5'd7; rsel2 = 5'd0;
      cycle();
      check_eq("t3_bypass", rdata1, rep(32'hA5));
      write_reg(0, 4'b1111, rep(32'h55), 1'b1);
      rsel1 = 5'd0; rsel2 = 5'd0;
      cycle();
      check_eq("t3_reg0_wr", rdata2, '0);
      idle_inputs();
      cycle();
      check_eq("t3_reg0_rd", rdata1, '0);

      // 4: scoreboard set/clear priority
      idle_inputs(); rsv_en = 1'b1; rsv_sel = 5'd9;
      cycle();
      idle_inputs(); rsel1 = 5'd9;
      #1;
      check_eq("t4_hazard_set", hazard, 1'b1);
      write_reg(9, 4'b0000, '0, 1'b1);
      rsv_en = 1'b1; rsv_sel = 5'd9;
      cycle();
      check_eq("t4_set_wins", busy_vec[9], 1'b1);
      idle_inputs(); write_reg(9, 4'b0000, '0, 1'b1);
      cycle();
      idle_inputs(); rsel1 = 5'd9;
      #1;
      check_eq("t4_hazard_clr", hazard, 1'b0);
      cycle();

      // 5: bulk clear after filling every register
      for (int r = 1; r < NREGS; r++) begin
         write_reg(r, 4'b1111, {$urandom | 32'h1, $urandom, $urandom, $urandom}, 1'b0);
         cycle();
      end
      idle_inputs(); rsv_en = 1'b1; rsv_sel = 5'd4;
      cycle();
      idle_inputs(); clr_req = 1'b1;
      cycle();
      run_clear(5, n);
      check_eq("t5_clr_len", n, 31);
      for (int r = 0; r < NREGS; r++) begin
         idle_inputs(); rsel1 = RBITS'(r); rsel2 = RBITS'(NREGS - 1 - r);
         cycle();
         check_eq("t5_zero", rdata1, '0);
      end
      check_eq("t5_busy_zero", busy_vec, '0);

      // 6: reset in the middle of a clear, then a full clear whose start
      // coincides with a write that must still commit
      idle_inputs(); clr_req = 1'b1;
      cycle();
      idle_inputs();
      for (int k = 0; k < 9; k++) cycle();
      reset_pulse();
      idle_inputs();
      cycle();
      check_eq("t6_idle_after_rst", clr_busy, 1'b0);
      write_reg(20, 4'b1111, rep(32'hCAFE_0020), 1'b0);
      clr_req = 1'b1;
      cycle();
      run_clear(-1, n);
      check_eq("t6_clr_len", n, 31);

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         idle_inputs();
         wen   = THREADS'($urandom_range(0, (1 << THREADS) - 1));
         wsel  = RBITS'($urandom_range(0, 7));
         wdata = {$urandom, $urandom, $urandom, $urandom};
         wlast = ($urandom_range(0, 3) == 0);
         rsel1 = ($urandom_range(0, 2) == 0) ? wsel : RBITS'($urandom_range(0, 7));
         rsel2 = RBITS'($urandom_range(0, NREGS - 1));
         rsv_en  = ($urandom_range(0, 2) == 0);
         rsv_sel = RBITS'($urandom_range(0, 7));
         clr_req = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
